// File: rtl/even_check_sched.sv
// even_check_sched: round-robin scheduler sharing one even/odd checker among
// N_REQ byte requesters, with a single response channel and saturating
// even/odd tallies.
module even_check_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_even,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          even_cnt,
  output logic [CNT_W-1:0]          odd_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned NR = N_REQ;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     lat_id;
  logic [DATA_W-1:0]   lat_data;
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic                accept;
  logic [ID_W-1:0]     ptr_after;

  // Round-robin search from rr_ptr plus next-state / grant decode.
  always_comb begin
    int unsigned idx;
    state_nxt   = state;
    req_ready   = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = CHECK;
        end
      end
      CHECK:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == RESP) && rsp_ready;
  assign ptr_after = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant capture, check result and response channel, RR pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_id    <= '0;
      lat_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_even  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            lat_id   <= grant_id;
            lat_data <= req_data[int'(grant_id)*DATA_W +: DATA_W];
          end
        end
        CHECK: begin
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          rsp_data  <= lat_data;
          rsp_even  <= ~lat_data[0];
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ptr_after;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

  // Saturating tallies of accepted responses; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else if (cnt_clr) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else if (accept) begin
      if (rsp_even) begin
        if (even_cnt != '1) even_cnt <= even_cnt + 1'b1;
      end else begin
        if (odd_cnt != '1) odd_cnt <= odd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_even_check_sched.sv
// Testbench for even_check_sched: directed transaction table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_even_check_sched;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic            rsp_ready;
  logic            cnt_clr;

  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_even;
  logic [15:0]     even_cnt, odd_cnt;
  logic            busy;

  logic [N-1:0]    s_req_ready;
  logic            s_rsp_valid;
  logic [1:0]      s_rsp_id;
  logic [DW-1:0]   s_rsp_data;
  logic            s_rsp_even;
  logic [3:0]      s_even_cnt, s_odd_cnt;
  logic            s_busy;

  even_check_sched #(.N_REQ(N), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_even(rsp_even),
    .cnt_clr(cnt_clr), .even_cnt(even_cnt), .odd_cnt(odd_cnt), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  even_check_sched #(.N_REQ(N), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .rsp_even(s_rsp_even),
    .cnt_clr(cnt_clr), .even_cnt(s_even_cnt), .odd_cnt(s_odd_cnt), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for response (t=%0t)", nm, $time);
  endfunction

  // Reference model: outstanding transaction queue with visibility timestamp.
  typedef struct {
    int          id;
    logic [7:0]  data;
  } pend_t;

  pend_t pend[$];
  int    m_ptr, cyc, vis_cyc;
  int    ev16, od16, ev4, od4;

  logic [N-1:0]    v_drv;
  logic [N*DW-1:0] d_drv;
  logic            rdy_drv, clr_drv;

  function automatic void model_reset();
    pend.delete();
    m_ptr = 0; cyc = 0; vis_cyc = 0;
    ev16 = 0; od16 = 0; ev4 = 0; od4 = 0;
  endfunction

  // One clock: apply inputs at negedge, compare, advance model, wait a cycle.
  task automatic step();
    logic [N-1:0] exp_rr;
    logic [7:0]   b;
    logic         exp_busy, exp_rv, acc;
    int           gid;
    pend_t        p;
    req_valid = v_drv;
    req_data  = d_drv;
    rsp_ready = rdy_drv;
    cnt_clr   = clr_drv;
    #1;
    exp_rr   = '0;
    gid      = -1;
    exp_busy = (pend.size() != 0);
    exp_rv   = exp_busy && (cyc >= vis_cyc);
    if (!exp_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (gid < 0 && v_drv[j]) gid = j;
      end
      if (gid >= 0) exp_rr[gid] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("even_cnt", 32'(even_cnt), ev16);
    chk("odd_cnt", 32'(odd_cnt), od16);
    chk("even_cnt4", 32'(s_even_cnt), ev4);
    chk("odd_cnt4", 32'(s_odd_cnt), od4);
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), pend[0].id);
      chk("rsp_data", 32'(rsp_data), 32'(pend[0].data));
      chk("rsp_even", 32'(rsp_even), 32'(pend[0].data % 2 == 0));
    end
    if (gid >= 0) begin
      b = d_drv[gid*DW +: DW];
      p.id = gid;
      p.data = b;
      pend.push_back(p);
      vis_cyc = cyc + 2;
    end
    acc = exp_rv && rdy_drv;
    if (clr_drv) begin
      ev16 = 0; od16 = 0; ev4 = 0; od4 = 0;
    end else if (acc) begin
      if (pend[0].data % 2 == 0) begin
        if (ev16 < 65535) ev16++;
        if (ev4 < 15) ev4++;
      end else begin
        if (od16 < 65535) od16++;
        if (od4 < 15) od4++;
      end
    end
    if (acc) begin
      m_ptr = (pend[0].id + 1) % N;
      void'(pend.pop_front());
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit           rst_before;
    logic [3:0]   valid;
    logic [31:0]  data;
    int           exp_id;
    logic [7:0]   exp_data;
    logic         exp_even;
  } txn_t;

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0; cnt_clr = 1'b0;
    v_drv = '0; rdy_drv = 1'b0; clr_drv = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_even", 32'(rsp_even), 0);
    chk("rst_even_cnt", 32'(even_cnt), 0);
    chk("rst_odd_cnt", 32'(odd_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run one transaction with rsp_ready high; optionally clear in accept cycle.
  task automatic run_txn(input txn_t t, input bit clr_acc);
    bit got;
    got = 1'b0;
    if (t.rst_before) do_reset();
    v_drv = t.valid; d_drv = t.data; rdy_drv = 1'b1; clr_drv = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        chk("tbl_id", 32'(rsp_id), t.exp_id);
        chk("tbl_data", 32'(rsp_data), 32'(t.exp_data));
        chk("tbl_even", 32'(rsp_even), 32'(t.exp_even));
        got = 1'b1;
        clr_drv = clr_acc;
      end
      step();
    end
    clr_drv = 1'b0;
    v_drv = '0;
    if (!got) timeout("tbl_txn");
  endtask

  txn_t tbl[$];

  initial begin
    txn_t t;
    int   od_before;
    bit   seen;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0; cnt_clr = 1'b0;
    v_drv = '0; d_drv = '0; rdy_drv = 1'b0; clr_drv = 1'b0;
    model_reset();

    tbl.push_back('{1'b1, 4'b0001, 32'h0000_00FF, 0, 8'd255, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 32'h0006_0F40, 0, 8'd64,  1'b1});
    tbl.push_back('{1'b0, 4'b1111, 32'h0006_0F40, 1, 8'd15,  1'b0});
    tbl.push_back('{1'b0, 4'b1111, 32'h0006_0F40, 2, 8'd6,   1'b1});
    tbl.push_back('{1'b0, 4'b1111, 32'h0006_0F40, 3, 8'd0,   1'b1});
    tbl.push_back('{1'b0, 4'b1111, 32'h0006_0F40, 0, 8'd64,  1'b1});
    tbl.push_back('{1'b0, 4'b0010, 32'h0908_0706, 1, 8'd7,   1'b0});
    tbl.push_back('{1'b0, 4'b1010, 32'h0908_0706, 3, 8'd9,   1'b0});
    tbl.push_back('{1'b0, 4'b1010, 32'h0908_0706, 1, 8'd7,   1'b0});
    tbl.push_back('{1'b0, 4'b1111, 32'h0908_0706, 2, 8'd8,   1'b1});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(tbl[i], 1'b0);
      if (i == 0) chk("odd_after_255", 32'(odd_cnt), 1);
      if (i == 4) begin
        chk("even_after_4", 32'(even_cnt), 3);
        chk("odd_after_4", 32'(odd_cnt), 1);
      end
    end

    // Backpressure: response held for 5 cycles with rsp_ready low.
    v_drv = 4'b0001; d_drv = 32'h0000_007F; rdy_drv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else step();
    end
    if (!seen) timeout("bp_wait");
    od_before = od16;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 127);
      chk("bp_even", 32'(rsp_even), 0);
      step();
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_odd_hold", 32'(odd_cnt), od_before);
    end
    rdy_drv = 1'b1;
    step();
    v_drv = '0;
    step();
    chk("bp_odd_inc", 32'(odd_cnt), od_before + 1);

    // Saturation of the 4-bit tallies, then clear in the accept cycle.
    do_reset();
    t = '{1'b0, 4'b0001, 32'h0000_0002, 0, 8'd2, 1'b1};
    for (int i = 0; i < 16; i++) run_txn(t, 1'b0);
    chk("sat_even4", 32'(s_even_cnt), 15);
    chk("even16_16", 32'(even_cnt), 16);
    run_txn(t, 1'b1);
    chk("clr_even", 32'(even_cnt), 0);
    chk("clr_odd", 32'(odd_cnt), 0);
    chk("clr_even4", 32'(s_even_cnt), 0);
    t = '{1'b0, 4'b0001, 32'h0000_0003, 0, 8'd3, 1'b0};
    run_txn(t, 1'b0);

    // Asynchronous reset while a response is pending.
    v_drv = 4'b0110; d_drv = 32'h0005_0400; rdy_drv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else step();
    end
    if (!seen) timeout("ar_wait");
    #2;
    rst = 1'b1;
    req_valid = '0; v_drv = '0;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_even", 32'(even_cnt), 0);
    chk("ar_odd", 32'(odd_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    t = '{1'b0, 4'b1111, 32'h0302_0100, 0, 8'd0, 1'b1};
    run_txn(t, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v_drv   = N'($urandom);
      d_drv   = $urandom;
      rdy_drv = ($urandom_range(0, 3) != 0);
      clr_drv = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
